fifo_uart_tx: RTL and testbench

FIFO_UART_TX -- requirements
Module: fifo_uart_tx

---
 rtl/uart_pkg.sv | 21 ++
 rtl/baud_gen.sv | 29 ++
 rtl/fifo_uart_tx.sv | 161 ++++++++++++++++
 tb/tb_fifo_uart_tx.sv | 286 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// uart_pkg: constants and state encoding shared by the UART transmit path.
// Build option: define PARITY_EN to add the PARITY state to the encoding.
package uart_pkg;

  // s_tick pulses per serial bit
  localparam int unsigned OVERSAMPLE = 16;

  // tick counter width; also covers a 2-stop-bit count of 32 ticks
  localparam int unsigned TICK_W = 5;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_START  = 3'd1,
    ST_DATA   = 3'd2,
`ifdef PARITY_EN
    ST_PARITY = 3'd3,
`endif
    ST_STOP   = 3'd4
  } state_t;

endpackage

// File: rtl/baud_gen.sv
// baud_gen: mod-M counter producing a one-clk s_tick pulse every M clocks.
module baud_gen #(
  parameter int unsigned M = 163
) (
  input  logic clk,
  input  logic reset,
  output logic s_tick
);

  localparam int unsigned CNT_W = (M > 1) ? $clog2(M) : 1;
  localparam logic [CNT_W-1:0] LAST = CNT_W'(M - 1);

  logic [CNT_W-1:0] cnt_reg;
  logic             tick_reg;

  // free-running divider; tick registered on the wrap cycle
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt_reg  <= '0;
      tick_reg <= 1'b0;
    end else begin
      cnt_reg  <= (cnt_reg == LAST) ? '0 : cnt_reg + CNT_W'(1);
      tick_reg <= (cnt_reg == LAST);
    end
  end

  assign s_tick = tick_reg;

endmodule

// File: rtl/fifo_uart_tx.sv
// fifo_uart_tx: pops words from an upstream FIFO and sends them as UART frames
// (start, DBIT data bits LSB first, optional even parity, SB_TICK-tick stop).
// Build option: define PARITY_EN to insert the even-parity bit after the data.
module fifo_uart_tx
  import uart_pkg::*;
#(
  parameter int unsigned DBIT    = 8,
  parameter int unsigned SB_TICK = 16
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            s_tick,
  input  logic            fifo_empty,
  input  logic [DBIT-1:0] fifo_data,
  output logic            fifo_rd,
  output logic            tx,
  output logic            tx_busy
);

  localparam int unsigned BIT_W = (DBIT > 1) ? $clog2(DBIT) : 1;
  localparam logic [TICK_W-1:0] OS_LAST  = TICK_W'(OVERSAMPLE - 1);
  localparam logic [TICK_W-1:0] SB_LAST  = TICK_W'(SB_TICK - 1);
  localparam logic [BIT_W-1:0]  BIT_LAST = BIT_W'(DBIT - 1);

  state_t            state_reg, state_next;
  logic [TICK_W-1:0] s_reg, s_next;
  logic [BIT_W-1:0]  n_reg, n_next;
  logic [DBIT-1:0]   b_reg, b_next;
  logic              tx_reg, tx_next;
  logic              busy_reg, busy_next;
`ifdef PARITY_EN
  logic              par_reg, par_next;
`endif

  // state and datapath registers; reset forces the line idle immediately
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_reg <= ST_IDLE;
      s_reg     <= '0;
      n_reg     <= '0;
      b_reg     <= '0;
      tx_reg    <= 1'b1;
      busy_reg  <= 1'b0;
`ifdef PARITY_EN
      par_reg   <= 1'b0;
`endif
    end else begin
      state_reg <= state_next;
      s_reg     <= s_next;
      n_reg     <= n_next;
      b_reg     <= b_next;
      tx_reg    <= tx_next;
      busy_reg  <= busy_next;
`ifdef PARITY_EN
      par_reg   <= par_next;
`endif
    end
  end

  // next state: pop in IDLE, then count 16 ticks per bit (SB_TICK in STOP)
  always_comb begin
    state_next = state_reg;
    s_next     = s_reg;
    n_next     = n_reg;
    b_next     = b_reg;
`ifdef PARITY_EN
    par_next   = par_reg;
`endif
    case (state_reg)
      ST_IDLE: begin
        if (!fifo_empty) begin
          state_next = ST_START;
          s_next     = '0;
          n_next     = '0;
          b_next     = fifo_data;
`ifdef PARITY_EN
          par_next   = ^fifo_data;
`endif
        end
      end
      ST_START: begin
        if (s_tick) begin
          if (s_reg == OS_LAST) begin
            s_next     = '0;
            state_next = ST_DATA;
          end else begin
            s_next = s_reg + TICK_W'(1);
          end
        end
      end
      ST_DATA: begin
        if (s_tick) begin
          if (s_reg == OS_LAST) begin
            s_next = '0;
            b_next = b_reg >> 1;
            if (n_reg == BIT_LAST) begin
`ifdef PARITY_EN
              state_next = ST_PARITY;
`else
              state_next = ST_STOP;
`endif
            end else begin
              n_next = n_reg + BIT_W'(1);
            end
          end else begin
            s_next = s_reg + TICK_W'(1);
          end
        end
      end
`ifdef PARITY_EN
      ST_PARITY: begin
        if (s_tick) begin
          if (s_reg == OS_LAST) begin
            s_next     = '0;
            state_next = ST_STOP;
          end else begin
            s_next = s_reg + TICK_W'(1);
          end
        end
      end
`endif
      ST_STOP: begin
        if (s_tick) begin
          if (s_reg == SB_LAST) begin
            s_next     = '0;
            state_next = ST_IDLE;
          end else begin
            s_next = s_reg + TICK_W'(1);
          end
        end
      end
      default: begin
        state_next = ST_IDLE;
      end
    endcase
  end

  // outputs: pop strobe in the IDLE pop cycle; line/busy follow the next state
  always_comb begin
    fifo_rd   = 1'b0;
    tx_next   = 1'b1;
    busy_next = 1'b1;
    if ((state_reg == ST_IDLE) && !fifo_empty) begin
      fifo_rd = 1'b1;
    end
    case (state_next)
      ST_IDLE:   busy_next = 1'b0;
      ST_START:  tx_next   = 1'b0;
      ST_DATA:   tx_next   = b_next[0];
`ifdef PARITY_EN
      ST_PARITY: tx_next   = par_next;
`endif
      ST_STOP:   tx_next   = 1'b1;
      default:   busy_next = 1'b0;
    endcase
  end

  assign tx      = tx_reg;
  assign tx_busy = busy_reg;

endmodule

// File: tb/tb_fifo_uart_tx.sv
// tb_fifo_uart_tx: scoreboard bench for fifo_uart_tx with FIFO and line models.
`timescale 1ns/1ps
module tb_fifo_uart_tx;

  localparam int unsigned DBIT = 8;
  localparam int unsigned SB1  = 16;
  localparam int unsigned SB2  = 32;
`ifdef PARITY_EN
  localparam int unsigned PBITS = 1;
`else
  localparam int unsigned PBITS = 0;
`endif
  localparam int unsigned FRAME1 = 16 * (DBIT + 1 + PBITS) + SB1;

  logic clk = 1'b0;
  logic reset;
  logic tick1, tick4;
  logic empty1, empty2;
  logic [7:0] data1, data2;
  logic rd1, rd2, tx1, tx2, busy1, busy2;

  always #5 clk = ~clk;

  baud_gen #(.M(1)) u_bg1 (.clk(clk), .reset(reset), .s_tick(tick1));
  baud_gen #(.M(4)) u_bg4 (.clk(clk), .reset(reset), .s_tick(tick4));

  fifo_uart_tx #(.DBIT(DBIT), .SB_TICK(SB1)) u_dut (
    .clk(clk), .reset(reset), .s_tick(tick1), .fifo_empty(empty1),
    .fifo_data(data1), .fifo_rd(rd1), .tx(tx1), .tx_busy(busy1));

  fifo_uart_tx #(.DBIT(DBIT), .SB_TICK(SB2)) u_dut2 (
    .clk(clk), .reset(reset), .s_tick(tick4), .fifo_empty(empty2),
    .fifo_data(data2), .fifo_rd(rd2), .tx(tx2), .tx_busy(busy2));

  int n_cmp = 0;
  int n_bad = 0;
  int cyc = 0;
  int pops1 = 0, pops2 = 0, viol = 0;
  int popc1[$];
  logic [7:0] fq1[$], fq2[$], sb[$];
  logic [7:0] junk2 = 8'h96;
  logic sel = 1'b0;
  logic rx_en = 1'b1;
  logic rx_active = 1'b0;

  wire tx_m   = sel ? tx2 : tx1;
  wire busy_m = sel ? busy2 : busy1;
  wire tick_m = sel ? tick4 : tick1;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic refresh();
    empty1 = (fq1.size() == 0);
    data1  = empty1 ? 8'hEE : fq1[0];
    empty2 = (fq2.size() == 0);
    data2  = empty2 ? junk2 : fq2[0];
  endtask

  task automatic push_word(input logic which, input logic [7:0] w);
    @(posedge clk); #2;
    if (which) fq2.push_back(w);
    else fq1.push_back(w);
    sb.push_back(w);
    refresh();
  endtask

  always @(posedge clk) cyc <= cyc + 1;

  // FIFO model: sample the pop strobe mid-cycle, retire the head after the edge
  initial begin : fifo_pop
    logic r1, r2;
    forever begin
      @(negedge clk);
      r1 = rd1;
      r2 = rd2;
      if ((rd1 && empty1) || (rd2 && empty2)) viol++;
      if (r1) begin pops1++; popc1.push_back(cyc); end
      if (r2) pops2++;
      @(posedge clk); #1;
      if (r1 && fq1.size() > 0) void'(fq1.pop_front());
      if (r2 && fq2.size() > 0) void'(fq2.pop_front());
      refresh();
    end
  end

  // line receiver: checks every sample of each bit, bit ends after its tick count
  initial begin : rx
    logic prev, obs, bad_busy, aborted;
    logic [7:0] w;
    logic bv[12];
    int bt[12];
    int nb, cnt, cyc_b, frame_cyc, div, sbt;
    prev = 1'b1;
    forever begin
      @(negedge clk);
      if (rx_en && !reset && prev && !tx_m) begin
        rx_active = 1'b1;
        if (sb.size() == 0) begin
          check("unexpected_frame", 32'(1), 32'(0));
          w = 8'h00;
        end else begin
          w = sb.pop_front();
        end
        div = sel ? 4 : 1;
        sbt = sel ? int'(SB2) : int'(SB1);
        nb = 0;
        bv[nb] = 1'b0; bt[nb] = 16; nb++;
        for (int i = 0; i < int'(DBIT); i++) begin
          bv[nb] = w[i]; bt[nb] = 16; nb++;
        end
        if (PBITS != 0) begin
          bv[nb] = ^w; bt[nb] = 16; nb++;
        end
        bv[nb] = 1'b1; bt[nb] = sbt; nb++;
        frame_cyc = 0;
        bad_busy = 1'b0;
        aborted = 1'b0;
        for (int b = 0; b < nb; b++) begin
          cnt = 0;
          cyc_b = 0;
          obs = bv[b];
          for (int k = 0; k < 400; k++) begin
            if (k > 0 || b > 0) @(negedge clk);
            if (reset) begin aborted = 1'b1; break; end
            if (tx_m !== bv[b] && obs === bv[b]) obs = tx_m;
            if (busy_m !== 1'b1) bad_busy = 1'b1;
            cyc_b++;
            frame_cyc++;
            if (tick_m) cnt++;
            if (cnt == bt[b]) break;
          end
          if (aborted) break;
          if (cnt != bt[b]) check($sformatf("bit%0d_timeout", b), 32'(cnt), 32'(bt[b]));
          check($sformatf("w%02h_bit%0d", w, b), 32'(obs), 32'(bv[b]));
          if (b == nb - 1) check($sformatf("w%02h_stop_len", w), 32'(cyc_b), 32'(sbt * div));
        end
        if (!aborted) begin
          check($sformatf("w%02h_busy_in_frame", w), 32'(bad_busy), 32'(0));
          if (div == 1) check($sformatf("w%02h_frame_len", w), 32'(frame_cyc), 32'(FRAME1));
          @(negedge clk);
          if (!reset) begin
            check("gap_busy", 32'(busy_m), 32'(0));
            check("gap_tx", 32'(tx_m), 32'(1));
          end
        end
        prev = tx_m;
        rx_active = 1'b0;
      end else begin
        prev = tx_m;
      end
    end
  end

  task automatic wait_done(input string tag);
    logic done;
    done = 1'b0;
    for (int i = 0; i < 4000; i++) begin
      @(negedge clk); #1;
      if (fq1.size() == 0 && fq2.size() == 0 && sb.size() == 0 && !rx_active && !busy_m) begin
        done = 1'b1;
        break;
      end
    end
    if (!done) check({tag, "_timeout"}, 32'(0), 32'(1));
  endtask

  // pop 0x3C unchecked, reset after ncyc clocks, confirm abort and no re-send
  task automatic abort_test(input int ncyc, input logic exp_tx, input string tag);
    int p0, bad;
    logic popped;
    rx_en = 1'b0;
    @(posedge clk); #2;
    fq1.push_back(8'h3C);
    refresh();
    p0 = pops1;
    popped = 1'b0;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk); #1;
      if (pops1 != p0) begin popped = 1'b1; break; end
    end
    check({tag, "_popped"}, 32'(popped), 32'(1));
    repeat (ncyc) @(negedge clk);
    check({tag, "_pre_tx"}, 32'(tx1), 32'(exp_tx));
    check({tag, "_pre_busy"}, 32'(busy1), 32'(1));
    #2 reset = 1'b1;
    #1;
    check({tag, "_tx_async"}, 32'(tx1), 32'(1));
    check({tag, "_busy_async"}, 32'(busy1), 32'(0));
    check({tag, "_rd_async"}, 32'(rd1), 32'(0));
    repeat (2) @(posedge clk);
    #2 reset = 1'b0;
    p0 = pops1;
    bad = 0;
    for (int i = 0; i < 300; i++) begin
      @(negedge clk);
      if (tx1 !== 1'b1 || busy1 !== 1'b0) bad++;
    end
    check({tag, "_after_line"}, 32'(bad), 32'(0));
    check({tag, "_no_repop"}, 32'(pops1 - p0), 32'(0));
    rx_en = 1'b1;
  endtask

  initial begin : watchdog
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin : main
    int bad, p0;
    reset = 1'b1;
    refresh();
    repeat (3) @(posedge clk);
    #2;
    check("rst_tx", 32'(tx1), 32'(1));
    check("rst_busy", 32'(busy1), 32'(0));
    check("rst_rd", 32'(rd1), 32'(0));
    check("rst_tx2", 32'(tx2), 32'(1));
    reset = 1'b0;
    repeat (3) @(posedge clk);

    // single frame 0xA5
    push_word(1'b0, 8'hA5);
    wait_done("a5");
    check("a5_pops", 32'(pops1), 32'(1));

    // back-to-back 0x00, 0xFF
    @(posedge clk); #2;
    fq1.push_back(8'h00); fq1.push_back(8'hFF);
    sb.push_back(8'h00);  sb.push_back(8'hFF);
    refresh();
    wait_done("b2b");
    check("b2b_pops", 32'(pops1), 32'(3));
    if (popc1.size() == 3) check("b2b_pop_gap", 32'(popc1[2] - popc1[1]), 32'(FRAME1 + 1));
    else check("b2b_pop_count", 32'(popc1.size()), 32'(3));

    // empty FIFO for 1000 clocks
    p0 = pops1;
    bad = 0;
    for (int i = 0; i < 1000; i++) begin
      @(negedge clk);
      if (tx1 !== 1'b1 || busy1 !== 1'b0 || rd1 !== 1'b0) bad++;
    end
    check("idle_line", 32'(bad), 32'(0));
    check("idle_pops", 32'(pops1 - p0), 32'(0));

`ifdef PARITY_EN
    push_word(1'b0, 8'h07);
    push_word(1'b0, 8'h03);
    wait_done("parity");
`endif

    // resets mid-frame: during data bit 3 (tx=1) and during the start bit
    abort_test(70, 1'b1, "abort_bit3");
    abort_test(5, 1'b0, "abort_start");

    // 2 stop bits, tick every 4 clk, FIFO inputs disturbed mid-frame
    sel = 1'b1;
    push_word(1'b1, 8'hC3);
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (rx_active) break;
    end
    repeat (100) @(posedge clk);
    #2 junk2 = 8'h3C;
    refresh();
    repeat (100) @(posedge clk);
    push_word(1'b1, 8'h5A);
    wait_done("sb32");
    check("sb32_pops", 32'(pops2), 32'(2));
    sel = 1'b0;

    check("sb_drained", 32'(sb.size()), 32'(0));
    check("rd_while_empty", 32'(viol), 32'(0));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
